udp_rx_unpack: RTL and testbench



---
 rtl/udp_pkg.sv | 14 +
 rtl/pp_ram.sv | 23 ++
 rtl/udp_rx_unpack.sv | 204 ++++++++++++++++++++
 tb/tb_udp_rx_unpack.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP receive unpacker.
package udp_pkg;

  localparam int unsigned UDP_HDR_BYTES = 8;

  typedef logic [15:0] len_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM
  } rd_state_e;

endpackage

// File: rtl/pp_ram.sv
// Simple dual-port word RAM backing both ping-pong banks; registered read port.
module pp_ram #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // One write port, one read port with a single cycle of latency.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/udp_rx_unpack.sv
// Captures UDP payload words into a ping-pong buffer and replays each committed
// packet as a big-endian byte stream with valid/ready/last.
module udp_rx_unpack
  import udp_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned HDR_BYTES = UDP_HDR_BYTES
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_valid,
  input  logic [31:0]       wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              pkt_done,
  input  logic [15:0]       pkt_len,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned CapBytes = 4 << ADDR_W;

  // Write side
  logic        wb_q;
  logic        in_pkt_q;
  logic        drop_q;
  logic        drop_now;
  logic        ram_we;
  logic [31:0] pay;
  len_t        len_commit;
  len_t        len_q [2];
  logic [15:0] drop_cnt_q;
  logic [1:0]  full_q;
  logic [1:0]  full_set;
  logic [1:0]  full_clr;

  // Read side
  rd_state_e         state_q;
  logic              rb_q;
  logic [1:0]        k_q;
  logic [ADDR_W-1:0] wa_q;
  len_t              rem_q;
  logic [31:0]       sr_q;
  logic [7:0]        m_data_q;
  logic              m_valid_q;
  logic              m_last_q;
  logic              hs;
  logic              ram_re;
  logic [ADDR_W:0]   ram_raddr;
  logic [31:0]       ram_rdata;

  pp_ram #(
    .AW(ADDR_W + 1),
    .DW(32)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr({wb_q, wr_addr}),
    .wdata(wr_data),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // Drop decision, write enable and clamped payload length for the open packet.
  always_comb begin
    // Before the packet opens, the decision is what would be latched at open.
    drop_now = in_pkt_q ? drop_q : full_q[wb_q];
    ram_we   = wr_valid & ~drop_now;
    if (32'(pkt_len) <= HDR_BYTES) pay = '0;
    else                           pay = 32'(pkt_len) - HDR_BYTES;
    if (pay > CapBytes) pay = CapBytes;
    len_commit = len_t'(pay);
    full_set = '0;
    if (pkt_done && !drop_now) full_set[wb_q] = 1'b1;
  end

  // Packet open/commit, write-bank pointer, stored lengths and drop counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      wb_q       <= 1'b0;
      in_pkt_q   <= 1'b0;
      drop_q     <= 1'b0;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      drop_cnt_q <= '0;
    end else if (pkt_done) begin
      in_pkt_q <= 1'b0;
      drop_q   <= 1'b0;
      if (drop_now) begin
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end else begin
        len_q[wb_q] <= len_commit;
        wb_q        <= ~wb_q;
      end
    end else if (wr_valid && !in_pkt_q) begin
      in_pkt_q <= 1'b1;
      drop_q   <= full_q[wb_q];
    end
  end

  // Bank occupancy: writer sets, reader clears; never the same bank in one cycle.
  always_ff @(posedge clk) begin
    if (clr) full_q <= '0;
    else     full_q <= (full_q & ~full_clr) | full_set;
  end

  // Reader RAM requests and bank release.
  always_comb begin
    hs        = m_valid_q & m_ready;
    full_clr  = '0;
    ram_re    = 1'b0;
    ram_raddr = {rb_q, wa_q};
    case (state_q)
      IDLE: begin
        if (full_q[rb_q]) begin
          if (len_q[rb_q] == 16'd0) begin
            full_clr[rb_q] = 1'b1;
          end else begin
            ram_re    = 1'b1;
            ram_raddr = {rb_q, {ADDR_W{1'b0}}};
          end
        end
      end
      STREAM: begin
        // Prefetch at byte 2 so the next word is ready when byte 3 is taken.
        if (k_q == 2'd2) ram_re = 1'b1;
        if (hs && m_last_q) full_clr[rb_q] = 1'b1;
      end
      default: ;
    endcase
  end

  // Byte-serialising FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      rb_q      <= 1'b0;
      k_q       <= '0;
      wa_q      <= '0;
      rem_q     <= '0;
      sr_q      <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (full_q[rb_q]) begin
            if (len_q[rb_q] == 16'd0) begin
              rb_q <= ~rb_q;
            end else begin
              rem_q   <= len_q[rb_q];
              wa_q    <= ADDR_W'(1);
              state_q <= FETCH;
            end
          end
        end
        FETCH: begin
          sr_q      <= ram_rdata;
          m_data_q  <= ram_rdata[31:24];
          m_last_q  <= (rem_q == 16'd1);
          m_valid_q <= 1'b1;
          k_q       <= '0;
          state_q   <= STREAM;
        end
        STREAM: begin
          if (hs) begin
            rem_q <= rem_q - 16'd1;
            if (m_last_q) begin
              m_valid_q <= 1'b0;
              m_last_q  <= 1'b0;
              rb_q      <= ~rb_q;
              state_q   <= IDLE;
            end else begin
              m_last_q <= (rem_q == 16'd2);
              if (k_q == 2'd3) begin
                sr_q     <= ram_rdata;
                m_data_q <= ram_rdata[31:24];
                wa_q     <= wa_q + ADDR_W'(1);
                k_q      <= '0;
              end else begin
                sr_q     <= sr_q << 8;
                m_data_q <= sr_q[23:16];
                k_q      <= k_q + 2'd1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;
  assign drop_cnt = drop_cnt_q;
  assign busy     = (|full_q) | (state_q != IDLE);

endmodule

// File: tb/tb_udp_rx_unpack.sv
// Directed bench for udp_rx_unpack.
module tb_udp_rx_unpack;

  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          clr;
  logic          wr_valid;
  logic [31:0]   wr_data;
  logic [AW-1:0] wr_addr;
  logic          pkt_done;
  logic [15:0]   pkt_len;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          busy;
  logic [15:0]   drop_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cyc = 0;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         c;
  } rx_t;

  rx_t         rx_q[$];
  logic [31:0] wbuf [64];

  udp_rx_unpack #(
    .ADDR_W   (AW),
    .HDR_BYTES(8)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .wr_valid(wr_valid),
    .wr_data (wr_data),
    .wr_addr (wr_addr),
    .pkt_done(pkt_done),
    .pkt_len (pkt_len),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted byte, sampled mid-cycle.
  always @(negedge clk) begin
    if (clr === 1'b0 && m_valid === 1'b1 && m_ready === 1'b1)
      rx_q.push_back('{d: m_data, l: m_last, c: cyc});
  end

  task automatic do_reset();
    clr = 1'b1; wr_valid = 1'b0; pkt_done = 1'b0; wr_data = '0; wr_addr = '0;
    pkt_len = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    rx_q.delete();
  endtask

  task automatic send_pkt(input int n, input logic [15:0] len, input bit merge);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(i);
      wr_data  = wbuf[i];
      pkt_len  = len;
      pkt_done = merge && (i == n - 1);
      if (pkt_done) done_cyc = cyc;
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    pkt_done = 1'b0;
    if (!merge || n == 0) begin
      pkt_done = 1'b1;
      pkt_len  = len;
      done_cyc = cyc;
      @(posedge clk);
      #1;
      pkt_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_m_data got %h want 00", m_data); end
    total++; if (m_last !== 1'b0) begin bad++; $display("FAIL reset_m_last got %b want 0", m_last); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (drop_cnt !== 16'h0) begin bad++; $display("FAIL reset_drop_cnt got %h want 0", drop_cnt); end
  endtask

  task automatic test_basic();
    do_reset();
    m_ready = 1'b1;
    wbuf[0] = 32'h01020304; wbuf[1] = 32'h05060708; wbuf[2] = 32'h090A0B0C;
    send_pkt(3, 16'd20, 1'b0);
    for (int i = 0; i < 50 && rx_q.size() < 12; i++) @(posedge clk);
    #1;
    total++;
    if (rx_q.size() != 12) begin
      bad++; $display("FAIL basic_count got %0d want 12", rx_q.size());
    end else begin
      total++;
      if (rx_q[0].c - done_cyc != 3) begin
        bad++; $display("FAIL basic_latency got %0d want 3", rx_q[0].c - done_cyc);
      end
      for (int i = 0; i < 12; i++) begin
        total++;
        if (rx_q[i].d !== 8'(i + 1) || rx_q[i].l !== 1'(i == 11)) begin
          bad++; $display("FAIL basic_byte%0d got %h/%b want %h/%b", i, rx_q[i].d, rx_q[i].l,
                          8'(i + 1), i == 11);
        end
      end
      total++;
      if (rx_q[11].c - rx_q[0].c != 11) begin
        bad++; $display("FAIL basic_rate got %0d cycles want 11", rx_q[11].c - rx_q[0].c);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got %b want 0", busy); end
  endtask

  task automatic test_partial();
    logic [7:0] exp [5];
    exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    do_reset();
    m_ready = 1'b1;
    wbuf[0] = 32'hAABBCCDD; wbuf[1] = 32'hEEFF0011;
    // Final word and pkt_done land in the same cycle.
    send_pkt(2, 16'd13, 1'b1);
    for (int i = 0; i < 40 && rx_q.size() < 5; i++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (rx_q.size() != 5) begin
      bad++; $display("FAIL partial_count got %0d want 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (rx_q[i].d !== exp[i] || rx_q[i].l !== 1'(i == 4)) begin
          bad++; $display("FAIL partial_byte%0d got %h/%b want %h/%b", i, rx_q[i].d, rx_q[i].l,
                          exp[i], i == 4);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pd;
    logic       pl;
    logic       pv;
    logic       pr;
    int         stalls;
    do_reset();
    for (int j = 0; j < 16; j++)
      wbuf[j] = {8'(4 * j), 8'(4 * j + 1), 8'(4 * j + 2), 8'(4 * j + 3)};
    send_pkt(16, 16'd72, 1'b0);
    pv = 1'b0; pr = 1'b0; pd = '0; pl = 1'b0; stalls = 0;
    for (int i = 0; i < 600 && rx_q.size() < 64; i++) begin
      if (pv && !pr && m_valid === 1'b1) begin
        stalls++;
        total++;
        if (m_data !== pd || m_last !== pl) begin
          bad++; $display("FAIL bp_stable got %h/%b want %h/%b", m_data, m_last, pd, pl);
        end
      end
      m_ready = ($urandom_range(0, 2) == 0);
      pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    total++;
    if (stalls == 0) begin bad++; $display("FAIL bp_stalls got 0 want >0"); end
    total++;
    if (rx_q.size() != 64) begin
      bad++; $display("FAIL bp_count got %0d want 64", rx_q.size());
    end else begin
      for (int i = 0; i < 64; i++) begin
        total++;
        if (rx_q[i].d !== 8'(i) || rx_q[i].l !== 1'(i == 63)) begin
          bad++; $display("FAIL bp_byte%0d got %h/%b want %h/%b", i, rx_q[i].d, rx_q[i].l,
                          8'(i), i == 63);
        end
      end
    end
  endtask

  task automatic test_overflow_back_to_back();
    logic [7:0] exp [8];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_reset();
    m_ready = 1'b0;
    wbuf[0] = 32'h11223344; send_pkt(1, 16'd12, 1'b0); repeat (2) @(posedge clk); #1;
    wbuf[0] = 32'h55667788; send_pkt(1, 16'd12, 1'b0); repeat (2) @(posedge clk); #1;
    wbuf[0] = 32'h99AABBCC; send_pkt(1, 16'd12, 1'b0); repeat (2) @(posedge clk); #1;
    total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL ovf_drop_cnt got %0d want 1", drop_cnt); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ovf_busy got %b want 1", busy); end
    total++;
    if (m_valid !== 1'b1 || m_data !== 8'h11) begin
      bad++; $display("FAIL ovf_head got %b/%h want 1/11", m_valid, m_data);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 40 && rx_q.size() < 8; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (rx_q.size() != 8) begin
      bad++; $display("FAIL ovf_count got %0d want 8", rx_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (rx_q[i].d !== exp[i] || rx_q[i].l !== 1'(i == 3 || i == 7)) begin
          bad++; $display("FAIL ovf_byte%0d got %h/%b want %h/%b", i, rx_q[i].d, rx_q[i].l,
                          exp[i], i == 3 || i == 7);
        end
      end
      total++;
      if (rx_q[4].c - rx_q[3].c != 3) begin
        bad++; $display("FAIL b2b_gap got %0d cycles want 3", rx_q[4].c - rx_q[3].c);
      end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ovf_busy_end got %b want 0", busy); end
    total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL ovf_drop_end got %0d want 1", drop_cnt); end
  endtask

  task automatic test_zero_len();
    do_reset();
    m_ready = 1'b1;
    send_pkt(0, 16'd8, 1'b0);
    for (int i = 0; i < 3 && busy !== 1'b0; i++) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy got %b want 0", busy); end
    // Length below the header size also stores zero bytes.
    send_pkt(0, 16'd5, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    total++; if (rx_q.size() != 0) begin bad++; $display("FAIL zero_bytes got %0d want 0", rx_q.size()); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL zero_drop got %0d want 0", drop_cnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy2 got %b want 0", busy); end
    wbuf[0] = 32'h5A000000;
    send_pkt(1, 16'd9, 1'b0);
    for (int i = 0; i < 20 && rx_q.size() < 1; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (rx_q.size() != 1) begin
      bad++; $display("FAIL one_count got %0d want 1", rx_q.size());
    end else begin
      total++;
      if (rx_q[0].d !== 8'h5A || rx_q[0].l !== 1'b1) begin
        bad++; $display("FAIL one_byte got %h/%b want 5a/1", rx_q[0].d, rx_q[0].l);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b1;
    for (int j = 0; j < 4; j++)
      wbuf[j] = {8'(4 * j + 16), 8'(4 * j + 17), 8'(4 * j + 18), 8'(4 * j + 19)};
    send_pkt(4, 16'd24, 1'b0);
    for (int i = 0; i < 40 && rx_q.size() < 5; i++) begin @(posedge clk); #1; end
    total++; if (rx_q.size() < 5) begin bad++; $display("FAIL mid_start got %0d want 5", rx_q.size()); end
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_m_valid got %b want 0", m_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got %b want 0", busy); end
    total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL mid_drop got %0d want 0", drop_cnt); end
    rx_q.delete();
    wbuf[0] = 32'hC0C1C2C3; wbuf[1] = 32'hC4C5C6C7;
    send_pkt(2, 16'd16, 1'b0);
    for (int i = 0; i < 40 && rx_q.size() < 8; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (rx_q.size() != 8) begin
      bad++; $display("FAIL mid_count got %0d want 8", rx_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (rx_q[i].d !== 8'(8'hC0 + i) || rx_q[i].l !== 1'(i == 7)) begin
          bad++; $display("FAIL mid_byte%0d got %h/%b want %h/%b", i, rx_q[i].d, rx_q[i].l,
                          8'(8'hC0 + i), i == 7);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_backpressure();
    test_overflow_back_to_back();
    test_zero_len();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
